// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised ALU with S/Z/C/V flag register,
// valid/ready handshakes on both sides, an iterative shift-add multiplier
// and, when ALU_SEQ_DIV_EN is defined, an iterative restoring divider.
// Single-cycle ops complete on the accepting edge; MUL/DIV spend WIDTH
// cycles in BUSY and present their result from DONE.
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [WIDTH-1:0]   rem,
    output logic               wb_en,
    output logic               S,
    output logic               Z,
    output logic               C,
    output logic               V,
    output logic               hlt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [SHAMT_W:0]   W_E       = (SHAMT_W+1)'(WIDTH);
    localparam logic [SHAMT_W-1:0] LAST_ITER = {SHAMT_W{1'b1}};

    logic [1:0] state_reg;
    logic       accept;
    logic       is_multi;

    // single-cycle datapath
    logic [WIDTH:0]     add_ext, sub_ext, sll_ext, srl_ext, sra_ext;
    logic [SHAMT_W:0]   rol_back;
    logic [WIDTH-1:0]   rol_val;
    logic [WIDTH-1:0]   op_r, op_rem;
    logic               op_wb, op_wf, op_c, op_v, op_hlt;

    // multiplier state
    logic [2*WIDTH-1:0] mcand_reg, acc_reg, acc_next;
    logic [WIDTH-1:0]   mplier_reg;
    logic [SHAMT_W-1:0] iter_reg;

    // completion values for the multi-cycle ops
    logic [WIDTH-1:0]   fin_r, fin_rem;
    logic               fin_c, fin_v;

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0]   quo_reg, prem_reg, dvsr_reg;
    logic [WIDTH-1:0]   quo_next, prem_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               is_div_reg;
`endif

    assign in_ready = (state_reg == S_IDLE) && (!out_valid || out_ready);
    // flush has priority: an op offered in the flush cycle is dropped
    assign accept   = in_valid && in_ready && !flush;

`ifdef ALU_SEQ_DIV_EN
    assign is_multi = (opcode == 4'd12) || ((opcode == 4'd13) && (in2 != '0));
`else
    assign is_multi = (opcode == 4'd12);
`endif

    // Shared shifter/adder terms; the extra bit carries the last bit shifted out
    assign add_ext  = {1'b0, in1} + {1'b0, in2};
    assign sub_ext  = {1'b0, in1} - {1'b0, in2};
    assign sll_ext  = {1'b0, in2} << shamt;
    assign srl_ext  = {in2, 1'b0} >> shamt;
    assign sra_ext  = $signed({in2, 1'b0}) >>> shamt;
    assign rol_back = W_E - {1'b0, shamt};
    assign rol_val  = (in2 << shamt) | (in2 >> rol_back);

    // Decode the single-cycle ops into result, remainder and flag updates
    always_comb begin
        op_r   = '0;
        op_rem = '0;
        op_wb  = 1'b1;
        op_wf  = 1'b1;
        op_c   = 1'b0;
        op_v   = 1'b0;
        op_hlt = 1'b0;
        case (opcode)
            4'd0: begin
                op_r = add_ext[WIDTH-1:0];
                op_c = add_ext[WIDTH];
                op_v = (in1[WIDTH-1] == in2[WIDTH-1]) && (add_ext[WIDTH-1] != in1[WIDTH-1]);
            end
            4'd1, 4'd5: begin
                op_r  = sub_ext[WIDTH-1:0];
                op_c  = sub_ext[WIDTH];
                op_v  = (in1[WIDTH-1] != in2[WIDTH-1]) && (sub_ext[WIDTH-1] != in1[WIDTH-1]);
                op_wb = (opcode == 4'd1);
            end
            4'd2:  op_r = in1 & in2;
            4'd3:  op_r = in1 | in2;
            4'd4:  op_r = in1 ^ in2;
            4'd6:  op_r = in2;
            4'd8: begin
                op_r = sll_ext[WIDTH-1:0];
                op_c = sll_ext[WIDTH];
            end
            4'd9:  op_r = rol_val;
            4'd10: begin
                op_r = srl_ext[WIDTH:1];
                op_c = srl_ext[0];
            end
            4'd11: begin
                op_r = sra_ext[WIDTH:1];
                op_c = sra_ext[0];
            end
`ifdef ALU_SEQ_DIV_EN
            4'd13: begin
                // only the zero-divisor case completes here
                op_r   = '1;
                op_rem = in1;
                op_v   = 1'b1;
            end
`else
            4'd13: begin
                op_wb = 1'b0;
                op_wf = 1'b0;
            end
`endif
            4'd15: begin
                op_wb  = 1'b0;
                op_wf  = 1'b0;
                op_hlt = 1'b1;
            end
            4'd12: begin
                // handled by the iterative path
                op_wf = 1'b0;
            end
            default: begin
                // 7 and 14 are no-ops
                op_wb = 1'b0;
                op_wf = 1'b0;
            end
        endcase
    end

    // Next-iteration values; the final iteration feeds the result directly
    always_comb begin
        acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
`ifdef ALU_SEQ_DIV_EN
        div_shift = {prem_reg, quo_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, dvsr_reg};
        if (!div_diff[WIDTH]) begin
            prem_next = div_diff[WIDTH-1:0];
            quo_next  = {quo_reg[WIDTH-2:0], 1'b1};
        end else begin
            prem_next = div_shift[WIDTH-1:0];
            quo_next  = {quo_reg[WIDTH-2:0], 1'b0};
        end
`endif
        fin_r   = acc_next[WIDTH-1:0];
        fin_rem = '0;
        fin_c   = |acc_next[2*WIDTH-1:WIDTH];
        fin_v   = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        if (is_div_reg) begin
            fin_r   = quo_next;
            fin_rem = prem_next;
            fin_c   = 1'b0;
        end
`endif
    end

    // Iterative datapath: load on accept, one bit per BUSY cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            iter_reg   <= '0;
`ifdef ALU_SEQ_DIV_EN
            quo_reg    <= '0;
            prem_reg   <= '0;
            dvsr_reg   <= '0;
            is_div_reg <= 1'b0;
`endif
        end else if (accept && is_multi) begin
            mcand_reg  <= {{WIDTH{1'b0}}, in1};
            acc_reg    <= '0;
            mplier_reg <= in2;
            iter_reg   <= '0;
`ifdef ALU_SEQ_DIV_EN
            quo_reg    <= in1;
            prem_reg   <= '0;
            dvsr_reg   <= in2;
            is_div_reg <= (opcode == 4'd13);
`endif
        end else if (state_reg == S_BUSY) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            iter_reg   <= iter_reg + 1'b1;
`ifdef ALU_SEQ_DIV_EN
            quo_reg    <= quo_next;
            prem_reg   <= prem_next;
`endif
        end
    end

    // Control FSM, output registers and flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            rem       <= '0;
            wb_en     <= 1'b0;
            S         <= 1'b0;
            Z         <= 1'b0;
            C         <= 1'b0;
            V         <= 1'b0;
            hlt       <= 1'b0;
        end else if (flush) begin
            state_reg <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        if (is_multi) begin
                            state_reg <= S_BUSY;
                            out_valid <= 1'b0;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= op_r;
                            rem       <= op_rem;
                            wb_en     <= op_wb;
                            if (op_wf) begin
                                S <= op_r[WIDTH-1];
                                Z <= (op_r == '0);
                                C <= op_c;
                                V <= op_v;
                            end
                            if (op_hlt) begin
                                hlt <= 1'b1;
                            end
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (iter_reg == LAST_ITER) begin
                        state_reg <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= fin_r;
                        rem       <= fin_rem;
                        wb_en     <= 1'b1;
                        S         <= fin_r[WIDTH-1];
                        Z         <= (fin_r == '0);
                        C         <= fin_c;
                        V         <= fin_v;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_reg <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq (WIDTH=16). Expected values are
// hand-computed; divide expectations follow ALU_SEQ_DIV_EN.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [3:0]  shamt;
    logic [15:0] in1, in2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result, rem;
    logic        wb_en, S, Z, C, V, hlt;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .shamt(shamt), .in1(in1), .in2(in2),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .rem(rem), .wb_en(wb_en),
        .S(S), .Z(Z), .C(C), .V(V), .hlt(hlt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic s, input logic z, input logic c, input logic v);
        chk({tag, ".S"}, {31'd0, S}, {31'd0, s});
        chk({tag, ".Z"}, {31'd0, Z}, {31'd0, z});
        chk({tag, ".C"}, {31'd0, C}, {31'd0, c});
        chk({tag, ".V"}, {31'd0, V}, {31'd0, v});
    endtask

    // Called at a negedge; offers one op and returns just after the accept edge
    task automatic send(input logic [3:0] op, input logic [3:0] d, input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_at_offer", {31'd0, in_ready}, 32'd1);
        opcode   = op;
        shamt    = d;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode   = 4'hE;
        in1      = 16'hDEAD;
        in2      = 16'hBEEF;
        shamt    = 4'hF;
    endtask

    // Counts edges from accept until out_valid; notes in_ready seen while waiting
    task automatic wait_result(output int lat, output bit rdy_seen);
        lat      = 0;
        rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) rdy_seen = 1'b1;
        end while (!out_valid && lat < 60);
        $display("op done: lat=%0d result=0x%h rem=0x%h wb_en=%0b SZCV=%0b%0b%0b%0b hlt=%0b",
                 lat, result, rem, wb_en, S, Z, C, V, hlt);
    endtask

    initial begin
        int lat;
        bit rs;
        bit seen;

        rst_n = 1'b0; in_valid = 1'b0; opcode = 4'd0; shamt = 4'd0;
        in1 = 16'd0; in2 = 16'd0; flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst.result", {16'd0, result}, 32'd0);
        chk("rst.rem", {16'd0, rem}, 32'd0);
        chk("rst.wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.hlt", {31'd0, hlt}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk_flags("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD signed overflow
        send(4'd0, 4'd0, 16'h7FFF, 16'h0001);
        wait_result(lat, rs);
        chk("add.lat", lat, 1);
        chk("add.result", {16'd0, result}, 32'h8000);
        chk("add.wb_en", {31'd0, wb_en}, 32'd1);
        chk_flags("add", 1, 0, 0, 1);

        // SUB with borrow, back-to-back with the ADD result
        send(4'd1, 4'd0, 16'h0003, 16'h0005);
        wait_result(lat, rs);
        chk("sub.lat", lat, 1);
        chk("sub.result", {16'd0, result}, 32'hFFFE);
        chk_flags("sub", 1, 0, 1, 0);

        // CMP equal
        send(4'd5, 4'd0, 16'h0005, 16'h0005);
        wait_result(lat, rs);
        chk("cmp.wb_en", {31'd0, wb_en}, 32'd0);
        chk_flags("cmp", 0, 1, 0, 0);

        // Shifts on 0x8001
        send(4'd11, 4'd4, 16'h0000, 16'h8001);
        wait_result(lat, rs);
        chk("sra.result", {16'd0, result}, 32'hF800);
        chk_flags("sra", 1, 0, 0, 0);
        send(4'd8, 4'd1, 16'h0000, 16'h8001);
        wait_result(lat, rs);
        chk("sll.result", {16'd0, result}, 32'h0002);
        chk_flags("sll", 0, 0, 1, 0);
        send(4'd9, 4'd0, 16'h0000, 16'h8001);
        wait_result(lat, rs);
        chk("slr.result", {16'd0, result}, 32'h8001);
        chk_flags("slr", 1, 0, 0, 0);
        send(4'd9, 4'd4, 16'h0000, 16'h8001);
        wait_result(lat, rs);
        chk("slr4.result", {16'd0, result}, 32'h0018);
        send(4'd10, 4'd1, 16'h0000, 16'h8001);
        wait_result(lat, rs);
        chk("srl.result", {16'd0, result}, 32'h4000);
        chk_flags("srl", 0, 0, 1, 0);

        // Logic ops
        send(4'd2, 4'd0, 16'hF0F0, 16'hFF00);
        wait_result(lat, rs);
        chk("and.result", {16'd0, result}, 32'hF000);
        send(4'd3, 4'd0, 16'hF0F0, 16'h0F00);
        wait_result(lat, rs);
        chk("or.result", {16'd0, result}, 32'hFFF0);
        send(4'd4, 4'd0, 16'hFFFF, 16'hFFFF);
        wait_result(lat, rs);
        chk("xor.result", {16'd0, result}, 32'h0000);
        chk_flags("xor", 0, 1, 0, 0);

        // NOP leaves flags alone
        send(4'd7, 4'd0, 16'h1234, 16'h8000);
        wait_result(lat, rs);
        chk("nop.wb_en", {31'd0, wb_en}, 32'd0);
        chk_flags("nop", 0, 1, 0, 0);

        // MOV
        send(4'd6, 4'd0, 16'h0001, 16'h8000);
        wait_result(lat, rs);
        chk("mov.result", {16'd0, result}, 32'h8000);
        chk_flags("mov", 1, 0, 0, 0);

        // MUL 0x100*0x100
        send(4'd12, 4'd0, 16'h0100, 16'h0100);
        wait_result(lat, rs);
        chk("mul1.lat", lat, 17);
        chk("mul1.ready_in_busy", {31'd0, rs}, 32'd0);
        chk("mul1.ready_in_done", {31'd0, in_ready}, 32'd0);
        chk("mul1.result", {16'd0, result}, 32'h0000);
        chk("mul1.rem", {16'd0, rem}, 32'h0000);
        chk("mul1.wb_en", {31'd0, wb_en}, 32'd1);
        chk_flags("mul1", 0, 1, 1, 0);

        send(4'd12, 4'd0, 16'hFFFF, 16'hFFFF);
        wait_result(lat, rs);
        chk("mul2.lat", lat, 17);
        chk("mul2.result", {16'd0, result}, 32'h0001);
        chk_flags("mul2", 0, 0, 1, 0);

        send(4'd12, 4'd0, 16'h1234, 16'h0003);
        wait_result(lat, rs);
        chk("mul3.result", {16'd0, result}, 32'h369C);
        chk_flags("mul3", 0, 0, 0, 0);

        // DIV
        send(4'd13, 4'd0, 16'd100, 16'd7);
        wait_result(lat, rs);
`ifdef ALU_SEQ_DIV_EN
        chk("div.lat", lat, 17);
        chk("div.result", {16'd0, result}, 32'd14);
        chk("div.rem", {16'd0, rem}, 32'd2);
        chk("div.wb_en", {31'd0, wb_en}, 32'd1);
        chk_flags("div", 0, 0, 0, 0);
`else
        chk("div.lat", lat, 1);
        chk("div.result", {16'd0, result}, 32'd0);
        chk("div.rem", {16'd0, rem}, 32'd0);
        chk("div.wb_en", {31'd0, wb_en}, 32'd0);
        chk_flags("div", 0, 0, 0, 0);
`endif
        // flags before this DIV are nonzero-sensitive: set C first
        send(4'd12, 4'd0, 16'hFFFF, 16'hFFFF);
        wait_result(lat, rs);
        send(4'd13, 4'd0, 16'd5, 16'd0);
        wait_result(lat, rs);
        chk("div0.lat", lat, 1);
`ifdef ALU_SEQ_DIV_EN
        chk("div0.result", {16'd0, result}, 32'hFFFF);
        chk("div0.rem", {16'd0, rem}, 32'd5);
        chk_flags("div0", 1, 0, 0, 1);
`else
        chk("div0.result", {16'd0, result}, 32'd0);
        chk("div0.rem", {16'd0, rem}, 32'd0);
        chk_flags("div0", 0, 0, 1, 0);
`endif

        // Backpressure: result held for 3 cycles, extra offer ignored
        send(4'd0, 4'd0, 16'h0001, 16'h0001);
        out_ready = 1'b0;
        wait_result(lat, rs);
        chk("stall.result0", {16'd0, result}, 32'h0002);
        opcode = 4'd1; in1 = 16'h0009; in2 = 16'h0001; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall.out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall.result", {16'd0, result}, 32'h0002);
            chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
            chk_flags("stall", 0, 0, 0, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall.consumed", {31'd0, out_valid}, 32'd0);
        chk("stall.result_after", {16'd0, result}, 32'h0002);

        // flush mid-MUL
        send(4'd12, 4'd0, 16'h0100, 16'h0100);
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        $display("flush mid-MUL: out_valid_seen=%0b SZCV=%0b%0b%0b%0b", seen, S, Z, C, V);
        chk("flush.out_valid_seen", {31'd0, seen}, 32'd0);
        chk("flush.in_ready", {31'd0, in_ready}, 32'd1);
        chk_flags("flush", 0, 0, 0, 0);

        // flush beats a simultaneous accept
        opcode = 4'd0; in1 = 16'h0000; in2 = 16'h0000; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        $display("flush vs accept: out_valid=%0b Z=%0b", out_valid, Z);
        chk("flushacc.out_valid", {31'd0, out_valid}, 32'd0);
        chk("flushacc.Z", {31'd0, Z}, 32'd0);

        // HLT then a normal op while halted
        send(4'd15, 4'd0, 16'h0000, 16'h0000);
        wait_result(lat, rs);
        chk("hlt.lat", lat, 1);
        chk("hlt.hlt", {31'd0, hlt}, 32'd1);
        chk("hlt.wb_en", {31'd0, wb_en}, 32'd0);
        chk_flags("hlt", 0, 0, 0, 0);
        send(4'd0, 4'd0, 16'hFFFF, 16'h0001);
        wait_result(lat, rs);
        chk("posthlt.result", {16'd0, result}, 32'h0000);
        chk("posthlt.hlt", {31'd0, hlt}, 32'd1);
        chk_flags("posthlt", 0, 1, 1, 0);
        send(4'd0, 4'd0, 16'hFFFF, 16'h0002);
        wait_result(lat, rs);
        chk("add2.result", {16'd0, result}, 32'h0001);
        chk_flags("add2", 0, 0, 1, 0);

        // async reset mid-MUL clears outputs without a clock edge
        send(4'd12, 4'd0, 16'h0003, 16'h0005);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        $display("reset mid-MUL: result=0x%h hlt=%0b C=%0b wb_en=%0b", result, hlt, C, wb_en);
        chk("rstmul.result", {16'd0, result}, 32'd0);
        chk("rstmul.rem", {16'd0, rem}, 32'd0);
        chk("rstmul.wb_en", {31'd0, wb_en}, 32'd0);
        chk("rstmul.hlt", {31'd0, hlt}, 32'd0);
        chk("rstmul.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstmul.in_ready", {31'd0, in_ready}, 32'd1);
        chk_flags("rstmul", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
